// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and control-state type for the sequential ALU core.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AVG = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative right-shifting shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
// product/done present the accumulator value being written on the final iteration edge.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH:0]     upper_sum_s;
    logic [2*WIDTH-1:0] acc_nxt_s;

    // One iteration: conditional add into the upper half, then shift right with the carry.
    always_comb begin
        upper_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        if (mplier_r[0]) begin
            upper_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            upper_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        acc_nxt_s = {upper_sum_s, acc_r[WIDTH-1:1]};
    end

    assign product = acc_nxt_s;
    assign done    = (cnt_r == CNT_W'(1));

    // Operand capture on start, then iterate until the counter drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
            cnt_r    <= CNT_W'(WIDTH);
        end else if (cnt_r != '0) begin
            acc_r    <= acc_nxt_s;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CNT_W'(1);
        end else begin
            acc_r    <= acc_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: add / signed-magnitude sub / iterative mul / average, registered result.
// Optional ZF/OVF result flags are generated when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               busy
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic               zf,
    output logic               ovf
`endif
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               mul_start_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;
    logic               lt_s;
    logic [WIDTH-1:0]   add_x_s;
    logic [WIDTH-1:0]   add_y_s;
    logic               add_cin_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] res_s;
    logic               y_load_s;
    logic [2*WIDTH-1:0] y_nxt_s;
    logic [2*WIDTH-1:0] y_r;

    assign accept_s    = in_valid && (state_r == IDLE);
    assign mul_start_s = accept_s && (op == OP_MUL);
    assign in_ready    = (state_r == IDLE);
    assign out_valid   = (state_r == DONE);
    assign busy        = (state_r != IDLE);
    assign y           = y_r;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .product (mul_product_s),
        .done    (mul_done_s)
    );

    // Shared W+1-bit adder; sub orders the operands so the difference is always a magnitude.
    always_comb begin
        lt_s      = (a < b);
        add_x_s   = a;
        add_y_s   = b;
        add_cin_s = 1'b0;
        if (op == OP_SUB) begin
            add_x_s   = lt_s ? b : a;
            add_y_s   = lt_s ? ~a : ~b;
            add_cin_s = 1'b1;
        end else begin
            add_x_s   = a;
            add_y_s   = b;
            add_cin_s = 1'b0;
        end
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + (WIDTH+1)'(add_cin_s);
    end

    // Result encoding for the single-cycle operations.
    always_comb begin
        res_s = '0;
        case (op)
            OP_ADD:  res_s = {{(WIDTH-1){1'b0}}, sum_s};
            OP_SUB:  res_s = {lt_s, {(WIDTH-1){1'b0}}, sum_s[WIDTH-1:0]};
            OP_AVG:  res_s = {sum_s[0], {(WIDTH-1){1'b0}}, sum_s[WIDTH:1]};
            default: res_s = '0;
        endcase
    end

    // Y is loaded at the accept edge for add/sub/avg, or on the final multiply iteration.
    always_comb begin
        y_load_s = 1'b0;
        y_nxt_s  = y_r;
        if (state_r == MUL && mul_done_s) begin
            y_load_s = 1'b1;
            y_nxt_s  = mul_product_s;
        end else if (accept_s && op != OP_MUL) begin
            y_load_s = 1'b1;
            y_nxt_s  = res_s;
        end else begin
            y_load_s = 1'b0;
            y_nxt_s  = y_r;
        end
    end

    // Control state transitions.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = (op == OP_MUL) ? MUL : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result register; holds its value through backpressure and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r <= '0;
        end else if (y_load_s) begin
            y_r <= y_nxt_s;
        end else begin
            y_r <= y_r;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic zf_r;
    logic ovf_r;
    logic ovf_nxt_s;

    // Overflow exists only for an add carry or a multiply using the upper half.
    always_comb begin
        ovf_nxt_s = 1'b0;
        if (state_r == MUL) begin
            ovf_nxt_s = |mul_product_s[2*WIDTH-1:WIDTH];
        end else if (op == OP_ADD) begin
            ovf_nxt_s = sum_s[WIDTH];
        end else begin
            ovf_nxt_s = 1'b0;
        end
    end

    // Flags are captured on the same edge as Y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (y_load_s) begin
            zf_r  <= (y_nxt_s == '0);
            ovf_r <= ovf_nxt_s;
        end else begin
            zf_r  <= zf_r;
            ovf_r <= ovf_r;
        end
    end

    assign zf  = zf_r;
    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=4; inputs driven and outputs sampled on the falling edge.
module tb_alu_seq_core;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [1:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] y;
    logic           busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic           zf;
    logic           ovf;
`endif

    int tests;
    int fails;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .zf        (zf),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1; k counts clock edges after the accept edge until out_valid.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [1:0] opv, input logic [2*W-1:0] exp_y, input int exp_k);
        int k;
        a         = av;
        b         = bv;
        op        = opv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        k        = 0;
        while (!out_valid && k < 20) begin
            check({tag, " in_ready busy"}, {15'd0, in_ready}, 16'd0);
            check({tag, " busy"}, {15'd0, busy}, 16'd1);
            @(negedge clk);
            k++;
        end
        check({tag, " out_valid"}, {15'd0, out_valid}, 16'd1);
        check({tag, " latency"}, k[15:0], exp_k[15:0]);
        check({tag, " y"}, {8'd0, y}, {8'd0, exp_y});
        @(negedge clk);
        check({tag, " back to idle"}, {14'd0, in_ready, out_valid}, 16'h0002);
        check({tag, " y kept"}, {8'd0, y}, {8'd0, exp_y});
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset in_ready", {15'd0, in_ready}, 16'd1);
        check("reset out_valid", {15'd0, out_valid}, 16'd0);
        check("reset busy", {15'd0, busy}, 16'd0);
        check("reset y", {8'd0, y}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add 9+8",   4'd9,  4'd8,  2'b00, 8'h11, 0);
        run_op("add 15+15", 4'd15, 4'd15, 2'b00, 8'h1E, 0);

        // Reset two cycles into a 15*15 multiply must abort it immediately.
        a        = 4'd15;
        b        = 4'd15;
        op       = 2'b10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmul busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmul out_valid", {15'd0, out_valid}, 16'd0);
        check("rstmul y", {8'd0, y}, 16'd0);
        check("rstmul busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmul in_ready", {15'd0, in_ready}, 16'd1);
        run_op("add 1+1 after rst", 4'd1, 4'd1, 2'b00, 8'h02, 0);

        run_op("sub 3-5",  4'd3,  4'd5,  2'b01, 8'h82, 0);
        run_op("sub 5-5",  4'd5,  4'd5,  2'b01, 8'h00, 0);
        run_op("sub 12-4", 4'd12, 4'd4,  2'b01, 8'h08, 0);
        run_op("sub 0-15", 4'd0,  4'd15, 2'b01, 8'h8F, 0);

        run_op("mul 15*15", 4'd15, 4'd15, 2'b10, 8'hE1, 4);
        run_op("mul 3*5",   4'd3,  4'd5,  2'b10, 8'h0F, 4);
        run_op("mul 0*9",   4'd0,  4'd9,  2'b10, 8'h00, 4);
        run_op("mul 6*1",   4'd6,  4'd1,  2'b10, 8'h06, 4);

        run_op("avg 7+8",   4'd7,  4'd8,  2'b11, 8'h87, 0);
        run_op("avg 15+15", 4'd15, 4'd15, 2'b11, 8'h0F, 0);

        // Backpressure: result held while new requests are presented and ignored.
        out_ready = 1'b0;
        a         = 4'd2;
        b         = 4'd3;
        op        = 2'b00;
        in_valid  = 1'b1;
        @(negedge clk);
        a  = 4'd7;
        b  = 4'd7;
        op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", {15'd0, out_valid}, 16'd1);
            check("bp y", {8'd0, y}, 16'h0005);
            check("bp in_ready", {15'd0, in_ready}, 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release idle", {14'd0, in_ready, out_valid}, 16'h0002);
        check("bp release y", {8'd0, y}, 16'h0005);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp pending valid", {15'd0, out_valid}, 16'd1);
        check("bp pending y", {8'd0, y}, 16'h000E);
        @(negedge clk);
        check("bp final idle", {15'd0, in_ready}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU core.
- Same four operations: add, signed-magnitude subtract, multiply, average.
- Operand width is set by WIDTH. Results are registered. Multiply runs on an iterative shift-add datapath instead of an array multiplier.
- Sits between the operand/opcode source and the result consumer. Valid/ready on both sides.

Parameters:
- WIDTH, 4, operand width in bits. Legal range 2..16. Result width is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter. Derived; do not override.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operands and opcode are valid.
- IN_READY  output  1  core can accept a new operation.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- OP  input  2  opcode: 00 add, 01 sub, 10 mul, 11 avg.
- OUT_VALID  output  1  Y holds a completed result.
- OUT_READY  input  1  consumer accepts Y.
- Y  output  2*WIDTH  result (encoding below).
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, IN_READY=1, OUT_VALID=0, Y=0, BUSY=0, all internal registers cleared.
- Accept: happens on the rising edge where IN_VALID && IN_READY. A, B and OP are captured then; later changes to them are ignored.
- IN_READY = (state==IDLE). It is decoded from the state register only, with no combinational path from IN_VALID or OUT_READY.
- States: IDLE, MUL, DONE.
  - IDLE -> DONE on accepting add, sub or avg. Y is written at the accept edge, so latency is 1.
  - IDLE -> MUL on accepting mul. Accumulator is cleared, counter is loaded with WIDTH.
  - MUL: each edge, if multiplier LSB=1 then add the multiplicand into the upper half of the accumulator; then shift right by one and decrement the counter.
  - MUL -> DONE on the edge where the counter reaches 0. Y gets the accumulator. Latency is exactly WIDTH cycles from accept to OUT_VALID.
  - DONE: OUT_VALID=1. DONE -> IDLE on the edge where OUT_READY=1.
  - Y and OUT_VALID stay stable while OUT_READY=0. Y keeps its last value after the handshake.
- Result encoding, W=WIDTH:
  - add: Y = {zeros, carry, sum[W-1:0]}, i.e. the full W+1-bit sum, zero-extended.
  - sub: Y[2W-1] = sign (1 when A<B). Y[W-1:0] = |A-B|. Other bits 0.
  - mul: Y = A*B, full 2W bits, unsigned.
  - avg: Y[W-1:0] = floor((A+B)/2), including the carry bit. Y[2W-1] = (A+B)[0], the remainder. Other bits 0.
- Boundaries:
  - A=B on sub gives Y=0 with sign 0 (no negative zero).
  - A=0 or B=0 on mul still takes WIDTH cycles; there is no early exit.
  - All-ones operands must not overflow on any operation.
  - Reset during MUL or DONE aborts the operation: OUT_VALID drops immediately and the result is lost.
  - IN_VALID asserted while busy is ignored and not queued. The upstream source must hold it until IN_READY.

Optional Feature:
- ALU_SEQ_FLAGS_EN.
- Defined: adds output ZF (1 bit) and output OVF (1 bit), both registered alongside Y and reset to 0.
  - ZF = (Y==0).
  - OVF = 1 when the result does not fit in W bits: add carry, or mul with Y[2W-1:W] != 0. It is 0 for sub and avg.
- Undefined: ZF and OVF ports are absent, and no flag logic is generated.

Decomposition:
- Package alu_seq_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_AVG=2'b11;
  - state enum (IDLE, MUL, DONE).
- One sub-module, alu_seq_mul: the iterative shift-add multiplier.
  - Inputs: start, operands.
  - Outputs: product, done pulse.
  - Parameterised by WIDTH and instantiated once.
  - Add/sub/avg stay inline in the core as one shared W+1-bit adder with operand mux.

Test Plan (WIDTH=4):
- Reset mid-multiply: accept mul 15*15, assert RST_N low 2 cycles later -> OUT_VALID=0 and Y=0 immediately, IN_READY=1 after release, and the next add 1+1 gives Y=8'h02.
- Add: A=9, B=8, OP=00, OUT_READY=1 -> OUT_VALID 1 cycle after accept, Y=8'h11, back to IDLE the next cycle.
- Sub negative and zero: 3-5 -> Y=8'h82; 5-5 -> Y=8'h00; 12-4 -> Y=8'h08.
- Mul latency and value: 15*15 -> OUT_VALID exactly 4 cycles after accept, Y=8'hE1. IN_READY=0 and BUSY=1 throughout.
- Avg with remainder: 7+8 -> Y=8'h87; 15+15 -> Y=8'h0F.
- Backpressure: hold OUT_READY=0 for 5 cycles after add 2+3 with new IN_VALID traffic -> Y=8'h05 stable, OUT_VALID held, new ops not accepted. Release -> the pending op is accepted once IDLE.
